// File: rtl/io_host_bridge.sv
// Host <-> memory-block bridge: input FIFO + handshake FSM into Input/InputRecv, output FIFO from OutWrite; IO_HOST_BRIDGE_OVERRUN_EN adds OverrunCnt.
// Latency: host push to Input is two edges minimum (no bypass); OutWrite to HostOutValid is one edge.
// Backpressure: HostInReady drops when the input FIFO is full; OutWrite words arriving at a full, unpopped output FIFO are dropped.
module io_host_bridge #(
  parameter int IN_DEPTH  = 4,
  parameter int OUT_DEPTH = 2
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic [15:0] HostInData,
  input  logic        HostInValid,
  output logic        HostInReady,
  output logic [15:0] HostOutData,
  output logic        HostOutValid,
  input  logic        HostOutReady,
  output logic [15:0] Input,
  input  logic        InputRecv,
  output logic        InputRst,
  input  logic [15:0] Output,
  input  logic        OutWrite,
  output logic [7:0]  OverrunCnt
);

  localparam int IN_AW  = $clog2(IN_DEPTH);
  localparam int OUT_AW = $clog2(OUT_DEPTH);
  localparam int IN_PW  = IN_AW + 1;
  localparam int OUT_PW = OUT_AW + 1;

  if (IN_DEPTH < 2 || IN_DEPTH > 16 || (IN_DEPTH & (IN_DEPTH - 1)) != 0) begin : gBadInDepth
    $error("IN_DEPTH must be a power of two in 2..16");
  end
  if (OUT_DEPTH < 2 || OUT_DEPTH > 16 || (OUT_DEPTH & (OUT_DEPTH - 1)) != 0) begin : gBadOutDepth
    $error("OUT_DEPTH must be a power of two in 2..16");
  end

  typedef enum logic [1:0] {
    IDLE,
    PRESENT,
    ACK,
    WAIT_CLR
  } inState_t;

  inState_t state, stateNext;

  // Input FIFO: the extra pointer MSB separates full from empty.
  logic [15:0]   inMem [IN_DEPTH];
  logic [IN_AW:0] inWrPtr, inRdPtr;
  logic          inFull, inEmpty, inPop, hostPush;
  logic [15:0]   inHead;

  assign inEmpty  = (inWrPtr == inRdPtr);
  assign inFull   = (inWrPtr[IN_AW] != inRdPtr[IN_AW]) &&
                    (inWrPtr[IN_AW-1:0] == inRdPtr[IN_AW-1:0]);
  assign inHead   = inMem[inRdPtr[IN_AW-1:0]];
  assign hostPush = HostInValid && HostInReady;
  assign HostInReady = !inFull;

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      inWrPtr <= '0;
      inRdPtr <= '0;
    end else begin
      if (hostPush) inWrPtr <= inWrPtr + IN_PW'(1);
      if (inPop)    inRdPtr <= inRdPtr + IN_PW'(1);
    end
  end

  always_ff @(posedge Clk) begin
    if (hostPush) inMem[inWrPtr[IN_AW-1:0]] <= HostInData;
  end

  // Output FIFO.
  logic [15:0]     outMem [OUT_DEPTH];
  logic [OUT_AW:0] outWrPtr, outRdPtr;
  logic            outFull, outEmpty, outPush, hostPop;

  assign outEmpty = (outWrPtr == outRdPtr);
  assign outFull  = (outWrPtr[OUT_AW] != outRdPtr[OUT_AW]) &&
                    (outWrPtr[OUT_AW-1:0] == outRdPtr[OUT_AW-1:0]);
  assign HostOutValid = !outEmpty;
  assign HostOutData  = outEmpty ? 16'h0000 : outMem[outRdPtr[OUT_AW-1:0]];
  assign hostPop  = HostOutValid && HostOutReady;
  // A same-edge host pop frees the slot a full FIFO needs for OutWrite.
  assign outPush  = OutWrite && (!outFull || hostPop);

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      outWrPtr <= '0;
      outRdPtr <= '0;
    end else begin
      if (outPush) outWrPtr <= outWrPtr + OUT_PW'(1);
      if (hostPop) outRdPtr <= outRdPtr + OUT_PW'(1);
    end
  end

  always_ff @(posedge Clk) begin
    if (outPush) outMem[outWrPtr[OUT_AW-1:0]] <= Output;
  end

  // Input handshake FSM.
  logic loadInput;

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state <= IDLE;
      Input <= 16'h0000;
    end else begin
      state <= stateNext;
      if (loadInput) Input <= inHead;
    end
  end

  always_comb begin
    stateNext = state;
    loadInput = 1'b0;
    inPop     = 1'b0;
    InputRst  = 1'b0;
    case (state)
      IDLE: begin
        // Waiting for InputRecv low also covers a flag left set across reset.
        if (!inEmpty && !InputRecv) begin
          loadInput = 1'b1;
          stateNext = PRESENT;
        end
      end
      PRESENT: begin
        if (InputRecv) stateNext = ACK;
      end
      ACK: begin
        InputRst  = 1'b1;
        inPop     = 1'b1;
        stateNext = WAIT_CLR;
      end
      WAIT_CLR: begin
        if (!InputRecv) stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

`ifdef IO_HOST_BRIDGE_OVERRUN_EN
  logic       outDrop;
  logic [7:0] overrunQ;

  assign outDrop = OutWrite && outFull && !hostPop;

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      overrunQ <= 8'h00;
    end else if (outDrop && overrunQ != 8'hFF) begin
      overrunQ <= overrunQ + 8'd1;
    end
  end

  assign OverrunCnt = overrunQ;
`else
  assign OverrunCnt = 8'h00;
`endif

endmodule

// File: tb/tb_io_host_bridge.sv
// Bench for io_host_bridge: directed handshake/FIFO scenarios, then random traffic against a queue-based model.
module tb_io_host_bridge;

  localparam int IN_DEPTH  = 4;
  localparam int OUT_DEPTH = 2;
`ifdef IO_HOST_BRIDGE_OVERRUN_EN
  localparam bit OVR_EN = 1'b1;
`else
  localparam bit OVR_EN = 1'b0;
`endif

  logic        Clk = 1'b0;
  logic        Rst = 1'b0;
  logic [15:0] HostInData = '0;
  logic        HostInValid = 1'b0;
  logic        HostInReady;
  logic [15:0] HostOutData;
  logic        HostOutValid;
  logic        HostOutReady = 1'b0;
  logic [15:0] Input;
  logic        InputRecv = 1'b0;
  logic        InputRst;
  logic [15:0] Output = '0;
  logic        OutWrite = 1'b0;
  logic [7:0]  OverrunCnt;

  int vectors = 0;
  int miscompares = 0;

  io_host_bridge #(.IN_DEPTH(IN_DEPTH), .OUT_DEPTH(OUT_DEPTH)) dut (
    .Clk(Clk), .Rst(Rst),
    .HostInData(HostInData), .HostInValid(HostInValid), .HostInReady(HostInReady),
    .HostOutData(HostOutData), .HostOutValid(HostOutValid), .HostOutReady(HostOutReady),
    .Input(Input), .InputRecv(InputRecv), .InputRst(InputRst),
    .Output(Output), .OutWrite(OutWrite), .OverrunCnt(OverrunCnt)
  );

  always #5 Clk = ~Clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic checkVal(input string tag, input logic [15:0] got, input logic [15:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  function automatic logic [15:0] ovrExp(input int n);
    return OVR_EN ? 16'(n) : 16'h0000;
  endfunction

  task automatic checkResetOutputs(input string tag);
    checkVal({tag, ".Input"},        Input, 16'h0000);
    checkVal({tag, ".InputRst"},     16'(InputRst), 16'd0);
    checkVal({tag, ".HostInReady"},  16'(HostInReady), 16'd1);
    checkVal({tag, ".HostOutValid"}, 16'(HostOutValid), 16'd0);
    checkVal({tag, ".HostOutData"},  HostOutData, 16'h0000);
    checkVal({tag, ".OverrunCnt"},   16'(OverrunCnt), 16'd0);
  endtask

  task automatic doReset();
    HostInValid = 1'b0; HostOutReady = 1'b0; OutWrite = 1'b0; InputRecv = 1'b0;
    Rst = 1'b1;
    #1;
    checkResetOutputs("rst");
    tick();
    Rst = 1'b0;
  endtask

  // Plays the memory block for one word already presented on Input.
  task automatic handshake(input logic [15:0] word);
    checkVal("hs.present", Input, word);
    InputRecv = 1'b1;
    tick();
    checkVal("hs.pulse", 16'(InputRst), 16'd1);
    InputRecv = 1'b0;
    tick();
    checkVal("hs.pulse_end", 16'(InputRst), 16'd0);
    checkVal("hs.hold", Input, word);
    tick();
    checkVal("hs.clr_wait", 16'(InputRst), 16'd0);
    tick();
  endtask

  logic [15:0] inQ[$];
  logic [15:0] outQ[$];
  int          phase;   // 0 waiting, 1 presenting, 2 acking, 3 awaiting flag clear
  logic [15:0] expInput;
  int          drops;
  bit          pushOk, popOk, outWasFull;

  initial begin
    doReset();

    // Single word round trip.
    HostInData = 16'hBEEF; HostInValid = 1'b1;
    tick();
    HostInValid = 1'b0;
    checkVal("beef.no_bypass", Input, 16'h0000);
    tick();
    checkVal("beef.input", Input, 16'hBEEF);
    handshake(16'hBEEF);
    checkVal("beef.idle_hold", Input, 16'hBEEF);

    // Fill the input FIFO with no handshake, then drain in order.
    HostInValid = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      HostInData = 16'(i);
      tick();
    end
    checkVal("fill.ready_low", 16'(HostInReady), 16'd0);
    checkVal("fill.first", Input, 16'h0001);
    HostInData = 16'h0005;
    tick();
    checkVal("fill.still_full", 16'(HostInReady), 16'd0);
    InputRecv = 1'b1;
    tick();
    checkVal("fill.pulse", 16'(InputRst), 16'd1);
    checkVal("fill.ack_full", 16'(HostInReady), 16'd0);
    InputRecv = 1'b0;
    tick();
    checkVal("fill.slot_free", 16'(HostInReady), 16'd1);
    tick();
    HostInValid = 1'b0;
    checkVal("fill.fifth_taken", 16'(HostInReady), 16'd0);
    tick();
    for (int i = 2; i <= 5; i++) handshake(16'(i));
    checkVal("fill.drained", 16'(HostInReady), 16'd1);

    // Output path ordering.
    OutWrite = 1'b1; Output = 16'hB00B;
    tick();
    Output = 16'h1234;
    tick();
    OutWrite = 1'b0;
    checkVal("out.valid", 16'(HostOutValid), 16'd1);
    checkVal("out.head0", HostOutData, 16'hB00B);
    HostOutReady = 1'b1;
    tick();
    checkVal("out.head1", HostOutData, 16'h1234);
    tick();
    checkVal("out.empty", 16'(HostOutValid), 16'd0);
    HostOutReady = 1'b0;

    // Overrun: full FIFO, three strobes dropped.
    OutWrite = 1'b1; Output = 16'h00A1;
    tick();
    Output = 16'h00A2;
    tick();
    for (int i = 0; i < 3; i++) begin
      Output = 16'hDD00 + 16'(i);
      tick();
    end
    OutWrite = 1'b0;
    checkVal("ovr.count3", 16'(OverrunCnt), ovrExp(3));
    checkVal("ovr.head", HostOutData, 16'h00A1);

    // Write and pop on the same edge of a full FIFO.
    OutWrite = 1'b1; Output = 16'hC3C3; HostOutReady = 1'b1;
    tick();
    OutWrite = 1'b0; HostOutReady = 1'b0;
    checkVal("swap.head", HostOutData, 16'h00A2);
    checkVal("swap.count", 16'(OverrunCnt), ovrExp(3));
    OutWrite = 1'b1; Output = 16'hDEAD;
    tick();
    OutWrite = 1'b0;
    checkVal("swap.still_full", 16'(OverrunCnt), ovrExp(4));
    HostOutReady = 1'b1;
    tick();
    checkVal("swap.tail", HostOutData, 16'hC3C3);
    tick();
    checkVal("swap.empty", 16'(HostOutValid), 16'd0);
    HostOutReady = 1'b0;

    // Reset in the middle of a handshake with InputRecv held high.
    OutWrite = 1'b1; Output = 16'hE1E1;
    tick();
    OutWrite = 1'b0;
    HostInValid = 1'b1; HostInData = 16'hDD01;
    tick();
    HostInValid = 1'b0;
    tick();
    checkVal("mid.present", Input, 16'hDD01);
    InputRecv = 1'b1;
    Rst = 1'b1;
    #1;
    checkResetOutputs("mid");
    tick();
    Rst = 1'b0;
    HostInValid = 1'b1; HostInData = 16'hF00D;
    tick();
    HostInValid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checkVal("mid.hold_idle", Input, 16'h0000);
      checkVal("mid.no_pulse", 16'(InputRst), 16'd0);
    end
    InputRecv = 1'b0;
    tick();
    checkVal("mid.resume", Input, 16'hF00D);
    handshake(16'hF00D);

    // Randomized traffic against the queue model.
    doReset();
    inQ.delete(); outQ.delete();
    phase = 0; expInput = 16'h0000; drops = 0;
    for (int c = 0; c < 3000; c++) begin
      HostInValid  = 1'($urandom_range(0, 1));
      HostInData   = 16'($urandom);
      HostOutReady = 1'($urandom_range(0, 3) < ((c / 250) % 4));
      OutWrite     = 1'($urandom_range(0, 1));
      Output       = 16'($urandom);
      InputRecv    = 1'($urandom_range(0, 1));

      pushOk     = HostInValid && (inQ.size() < IN_DEPTH);
      popOk      = HostOutReady && (outQ.size() > 0);
      outWasFull = (outQ.size() == OUT_DEPTH);
      case (phase)
        0: if (inQ.size() > 0 && !InputRecv) begin expInput = inQ[0]; phase = 1; end
        1: if (InputRecv) phase = 2;
        2: begin void'(inQ.pop_front()); phase = 3; end
        default: if (!InputRecv) phase = 0;
      endcase
      if (popOk) void'(outQ.pop_front());
      if (OutWrite) begin
        if (!outWasFull || popOk) outQ.push_back(Output);
        else if (drops < 255) drops++;
      end
      if (pushOk) inQ.push_back(HostInData);

      tick();
      checkVal("rnd.HostInReady", 16'(HostInReady), 16'(inQ.size() < IN_DEPTH));
      checkVal("rnd.HostOutValid", 16'(HostOutValid), 16'(outQ.size() > 0));
      if (outQ.size() > 0) checkVal("rnd.HostOutData", HostOutData, outQ[0]);
      checkVal("rnd.Input", Input, expInput);
      checkVal("rnd.InputRst", 16'(InputRst), 16'(phase == 2));
      checkVal("rnd.OverrunCnt", 16'(OverrunCnt), ovrExp(drops));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
